// File: rtl/ccx_stall_pkg.sv
// ccx_stall_pkg
//   Shared types and helpers for the CPX stall injector.
//   - stall_state_e : per-channel random-interval FSM state
//   - lfsr_taps()   : feedback tap mask for the supported LFSR widths (16/24/32)
//   - next_lfsr()   : one shift step of a left-shifting Fibonacci LFSR
//   - draw_len()    : interval length from min/random/mask with saturation
//   Helpers work on 32-bit containers plus an explicit width so they can be
//   shared by any parameterisation; callers cast the result back down.
package ccx_stall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FREE  = 2'd1,
    STALL = 2'd2
  } stall_state_e;

  localparam int unsigned MAX_W = 32;

  function automatic logic [31:0] width_mask(input int unsigned w);
    width_mask = 32'hFFFF_FFFF >> (MAX_W - w);
  endfunction

  // Maximal-length polynomials: x^16+x^14+x^13+x^11+1, x^24+x^23+x^22+x^17+1,
  // x^32+x^22+x^2+x^1+1. The top bit is always tapped, so the step is
  // invertible and a non-zero state never collapses to zero.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

  function automatic logic [31:0] next_lfsr(input logic [31:0] cur, input int unsigned w);
    logic fb;
    fb        = ^(cur & lfsr_taps(w));
    next_lfsr = ((cur << 1) | {31'd0, fb}) & width_mask(w);
  endfunction

  // len = min + (rnd & mask), saturated to the counter width; 0 becomes 1 so
  // an interval always lasts at least one cycle.
  function automatic logic [31:0] draw_len(input logic [31:0] min_l,
                                           input logic [31:0] rnd,
                                           input logic [31:0] mask,
                                           input int unsigned w);
    logic [32:0] sum;
    logic [31:0] max_v;
    max_v = width_mask(w);
    sum   = {1'b0, min_l} + {1'b0, rnd & mask};
    if (sum > {1'b0, max_v})
      draw_len = max_v;
    else if (sum == 33'd0)
      draw_len = 32'd1;
    else
      draw_len = sum[31:0];
  endfunction

endpackage

// File: rtl/ccx_stall_chan.sv
// ccx_stall_chan
//   One stall channel: LFSR, FREE/STALL interval FSM with down-counter,
//   sticky software stall and the atomic-pair gate.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     rand_en               enable random stalling
//     min_len, len_mask     interval length controls (used at each draw)
//     seed_ld, seed         reload LFSR with seed (zero replaced by 1)
//     stall_on, free_on     set / clear sticky software stall (clear wins)
//     atom_grant            first half of an atomic pair granted this cycle
//     stall                 gated stall to the arbiter
//     sw_stall, rand_stall  sticky software stall / ungated random stall
//
//   state | meaning
//   IDLE  | random stalling disabled, counter cleared
//   FREE  | random free interval, cnt cycles remaining
//   STALL | random stall interval, cnt cycles remaining
module ccx_stall_chan
  import ccx_stall_pkg::*;
#(
  parameter int                CNT_W    = 8,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] RST_SEED = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rand_en,
  input  logic [CNT_W-1:0]  min_len,
  input  logic [CNT_W-1:0]  len_mask,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic              stall_on,
  input  logic              free_on,
  input  logic              atom_grant,
  output logic              stall,
  output logic              sw_stall,
  output logic              rand_stall
);

  localparam logic [LFSR_W-1:0] RST_LFSR = (RST_SEED == '0) ? LFSR_W'(1) : RST_SEED;

  stall_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_draw;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed_nz;
  logic              sw_q, sw_d;
  logic              stall_q;

  assign seed_nz  = (seed == '0) ? LFSR_W'(1) : seed;
  assign len_draw = CNT_W'(draw_len(32'(min_len), 32'(lfsr_q[CNT_W-1:0]),
                                    32'(len_mask), CNT_W));
  // The LFSR free-runs, so every draw sees a fresh value without extra stepping.
  assign lfsr_d   = seed_ld ? seed_nz : LFSR_W'(next_lfsr(32'(lfsr_q), LFSR_W));
  assign sw_d     = (stall_on | sw_q) & ~free_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= RST_LFSR;
      sw_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sw_q    <= sw_d;
      stall_q <= stall;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!rand_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FREE;
          cnt_d   = len_draw;
        end
        FREE: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = STALL;
            cnt_d   = len_draw;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        STALL: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = FREE;
            cnt_d   = len_draw;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A stall may only start when no IFILL1 is being granted; once started it
  // is held regardless of atom_grant.
  always_comb begin
    rand_stall = (state_q == STALL);
    sw_stall   = sw_q;
    stall      = (rand_stall | sw_q) & ~(~stall_q & atom_grant);
  end

endmodule

// File: rtl/ccx_stall_gen.sv
// ccx_stall_gen
//   Parametrised CPX stall injector, one channel per destination arbiter.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     rand_en               enable random stalling (all channels)
//     min_len, len_mask     interval length = min_len + (lfsr & len_mask)
//     seed_ld, seed         reload LFSRs; channel i gets seed ^ i
//     stall_on, free_on     per-channel sticky software stall set / clear
//     atom_grant            per-channel IFILL1 grant, defers new stalls
//     stall                 per-channel gated stall (to arbiter stall2_a)
//     sw_stall, rand_stall  per-channel software / random stall state
//   Optional (CCX_STALL_STATS_EN defined):
//     stats_clr             clear all statistics counters
//     stall_cyc             per channel {deferral count, stall-cycle count},
//                           channel i at [2*CNT_W*i +: 2*CNT_W], saturating
module ccx_stall_gen
  import ccx_stall_pkg::*;
#(
  parameter int                NUM_CH   = 8,
  parameter int                CNT_W    = 8,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] RST_SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rand_en,
  input  logic [CNT_W-1:0]  min_len,
  input  logic [CNT_W-1:0]  len_mask,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic [NUM_CH-1:0] stall_on,
  input  logic [NUM_CH-1:0] free_on,
  input  logic [NUM_CH-1:0] atom_grant,
  output logic [NUM_CH-1:0] stall,
  output logic [NUM_CH-1:0] sw_stall,
  output logic [NUM_CH-1:0] rand_stall
`ifdef CCX_STALL_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [NUM_CH*CNT_W*2-1:0]  stall_cyc
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ccx_stall_chan #(
      .CNT_W    (CNT_W),
      .LFSR_W   (LFSR_W),
      .RST_SEED (RST_SEED ^ LFSR_W'(i))
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .rand_en    (rand_en),
      .min_len    (min_len),
      .len_mask   (len_mask),
      .seed_ld    (seed_ld),
      .seed       (seed ^ LFSR_W'(i)),
      .stall_on   (stall_on[i]),
      .free_on    (free_on[i]),
      .atom_grant (atom_grant[i]),
      .stall      (stall[i]),
      .sw_stall   (sw_stall[i]),
      .rand_stall (rand_stall[i])
    );

`ifdef CCX_STALL_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, defer_cnt_q;
    logic             defer;

    assign defer = (rand_stall[i] | sw_stall[i]) & ~stall[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stall_cnt_q <= '0;
        defer_cnt_q <= '0;
      end else if (stats_clr) begin
        stall_cnt_q <= '0;
        defer_cnt_q <= '0;
      end else begin
        if (stall[i] && (stall_cnt_q != '1))
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (defer && (defer_cnt_q != '1))
          defer_cnt_q <= defer_cnt_q + CNT_W'(1);
      end
    end

    assign stall_cyc[2*CNT_W*i +: 2*CNT_W] = {defer_cnt_q, stall_cnt_q};
`endif
  end

endmodule

// File: tb/tb_ccx_stall_gen.sv
module tb_ccx_stall_gen;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int LFSR_W = 16;
  localparam int SEED_CYC = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rand_en = 1'b0;
  logic [CNT_W-1:0]  min_len = '0;
  logic [CNT_W-1:0]  len_mask = '0;
  logic              seed_ld = 1'b0;
  logic [LFSR_W-1:0] seed = '0;
  logic [NUM_CH-1:0] stall_on = '0;
  logic [NUM_CH-1:0] free_on = '0;
  logic [NUM_CH-1:0] atom_grant = '0;
  logic [NUM_CH-1:0] stall, sw_stall, rand_stall;
`ifdef CCX_STALL_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [NUM_CH*CNT_W*2-1:0] stall_cyc;
`endif

  ccx_stall_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .LFSR_W (LFSR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rand_en    (rand_en),
    .min_len    (min_len),
    .len_mask   (len_mask),
    .seed_ld    (seed_ld),
    .seed       (seed),
    .stall_on   (stall_on),
    .free_on    (free_on),
    .atom_grant (atom_grant),
    .stall      (stall),
    .sw_stall   (sw_stall),
    .rand_stall (rand_stall)
`ifdef CCX_STALL_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .stall_cyc  (stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] so;
    logic [7:0] fo;
    logic [7:0] ag;
    logic [7:0] exp_stall;
    logic [7:0] exp_sw;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] stall;
    logic [7:0] sw;
    logic [7:0] rnd;
  } exp_t;

  vec_t       vecs[20];
  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] trace_a[SEED_CYC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [7:0] s, input logic [7:0] sw,
                          input logic [7:0] r);
    exp_t e;
    e.name  = name;
    e.stall = s;
    e.sw    = sw;
    e.rnd   = r;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if ({stall, sw_stall, rand_stall} !== {e.stall, e.sw, e.rnd}) begin
        n_fail++;
        $display("FAIL %s: got stall=%h sw=%h rand=%h, want stall=%h sw=%h rand=%h",
                 e.name, stall, sw_stall, rand_stall, e.stall, e.sw, e.rnd);
      end
    end
  endtask

  task automatic check_bool(input string name, input bit ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Random intervals with zero mask: every channel alternates eff free /
  // eff stall cycles, after one IDLE cycle (k = 0).
  task automatic run_periodic(input string name, input logic [7:0] ml, input int eff,
                              input int n);
    logic [7:0] e;
    rand_en  = 1'b0;
    min_len  = ml;
    len_mask = 8'h00;
    tick();
    tick();
    rand_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = (k >= 1 && (((k - 1) / eff) % 2 == 1)) ? 8'hFF : 8'h00;
      push_exp(name, e, 8'h00, e);
      @(negedge clk);
      pop_check();
      tick();
    end
  endtask

  task automatic seed_run(input bit second);
    int cur_run, max_run, prev, diff_ch;
    rand_en = 1'b0;
    tick();
    tick();
    tick();
    min_len  = 8'd1;
    len_mask = 8'h07;
    seed     = 16'h1234;
    seed_ld  = 1'b1;
    tick();
    seed_ld = 1'b0;
    rand_en = 1'b1;
    cur_run = 0;
    max_run = 0;
    prev    = -1;
    diff_ch = 0;
    for (int k = 0; k < SEED_CYC; k++) begin
      if (second) begin
        push_exp("seed_repro", trace_a[k], 8'h00, trace_a[k]);
        @(negedge clk);
        pop_check();
      end else begin
        @(negedge clk);
        trace_a[k] = rand_stall;
        if (rand_stall[0] != rand_stall[1]) diff_ch++;
        if (k > 1) begin
          if (int'(rand_stall[0]) == prev) cur_run++;
          else cur_run = 1;
          if (cur_run > max_run) max_run = cur_run;
        end
        prev = int'(rand_stall[0]);
      end
      tick();
    end
    if (!second) begin
      check_bool("run_len_max_le_8", max_run <= 8, max_run, 8);
      check_bool("run_len_varies", max_run >= 2, max_run, 2);
      check_bool("chan_seeds_differ", diff_ch > 0, diff_ch, 1);
    end
  endtask

  initial begin
    int t;
    vecs[0]  = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h05};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h05};
    vecs[3]  = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h05};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
    vecs[5]  = '{8'h08, 8'h08, 8'h00, 8'h04, 8'h04};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
    vecs[7]  = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h04};
    vecs[8]  = '{8'h00, 8'h04, 8'h00, 8'h04, 8'h04};
    vecs[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[11] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h04};
    vecs[12] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h04};
    vecs[13] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04};
    vecs[14] = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h04};
    vecs[15] = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h04};
    vecs[16] = '{8'h00, 8'h00, 8'h06, 8'h04, 8'h06};
    vecs[17] = '{8'h00, 8'h00, 8'h00, 8'h06, 8'h06};
    vecs[18] = '{8'h00, 8'hFF, 8'h00, 8'h06, 8'h06};
    vecs[19] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    tick();
    push_exp("reset_state", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    pop_check();
    tick();
    rst = 1'b0;
    tick();

    // Sticky software stall and atomic gating
    for (int i = 0; i < 20; i++) begin
      stall_on   = vecs[i].so;
      free_on    = vecs[i].fo;
      atom_grant = vecs[i].ag;
      push_exp($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_sw, 8'h00);
      @(negedge clk);
      pop_check();
      tick();
    end
    stall_on   = '0;
    free_on    = '0;
    atom_grant = '0;

    run_periodic("periodic_4", 8'd4, 4, 200);
    run_periodic("periodic_0", 8'd0, 1, 40);

    // rand_en dropped in the middle of a stall interval
    run_periodic("periodic_4b", 8'd4, 4, 3);
    t = 0;
    while (rand_stall[0] !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check_bool("stall_seen", t < 50, t, 50);
    tick();
    rand_en = 1'b0;
    push_exp("mid_stall_hold", 8'hFF, 8'h00, 8'hFF);
    @(negedge clk);
    pop_check();
    tick();
    push_exp("rand_en_drop", 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    pop_check();
    tick();

    seed_run(1'b0);
    seed_run(1'b1);

    // Asynchronous reset in the middle of a stall
    stall_on = 8'h10;
    tick();
    stall_on = 8'h00;
    t = 0;
    while (rand_stall[0] !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check_bool("stall_seen_rst", t < 50, t, 50);
    check_bool("sw_set_before_rst", sw_stall[4] === 1'b1, int'(sw_stall[4]), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 8'h00, 8'h00, 8'h00);
    pop_check();
    tick();
    rst = 1'b0;
    rand_en = 1'b0;
    tick();

    check_bool("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ccx_stall_gen.md
Name: ccx_stall_gen

Overview:
- Synthesizable, parametrised CPX stall injector for N destination channels; each channel's stall feeds its arbiter's stall2_a input.
- Replaces testbench-only random stalling. Per-channel LFSR-driven free/stall intervals are combined with sticky software stall_on/free_on requests.
- Never asserts a new stall in the cycle the first half of an atomic pair (IFILL1) is granted, so IFILL1/IFILL2 stay adjacent.
- Sits between the ccx arbiters and the stimulus/control layer. Usable in emulation and in RTL simulation.

Parameters:
NUM_CH, 8, number of channels (one per core/arbiter)
CNT_W, 8, width of interval length and counters
LFSR_W, 16, width of per-channel LFSR (taps from package table, supported 16/24/32)
RST_SEED, 16'hACE1, LFSR reset seed; channel i uses RST_SEED ^ i (forced non-zero)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rand_en  in  1  enable random stalling
min_len  in  CNT_W  minimum interval length (cycles)
len_mask  in  CNT_W  random span mask added to min_len
seed_ld  in  1  load seed into all channel LFSRs
seed  in  LFSR_W  seed value (channel i gets seed ^ i; all-zero replaced by 1)
stall_on  in  NUM_CH  set sticky software stall per channel
free_on  in  NUM_CH  clear sticky software stall per channel
atom_grant  in  NUM_CH  arbiter granted first half of an atomic pair this cycle
stall  out  NUM_CH  gated stall to arbiter
sw_stall  out  NUM_CH  current sticky software stall state
rand_stall  out  NUM_CH  current random stall state (ungated)

Behaviour:
- Reset: all FSMs in IDLE; counters 0; LFSR = per-channel seed; sw_stall = 0; stall = 0; rand_stall = 0; stall_q = 0.
- Interval length: len = min_len + (lfsr[CNT_W-1:0] & len_mask), saturating at 2^CNT_W-1. A len of 0 is treated as 1. Each draw advances the LFSR one step; otherwise it steps every cycle.
- Per-channel FSM:
  - IDLE: when rand_en = 1, draw len into cnt and go to FREE.
  - FREE: cnt decrements each cycle. When cnt = 1, draw len and go to STALL.
  - STALL: rand_stall = 1; cnt decrements each cycle. When cnt = 1, draw len and go to FREE.
  - rand_en = 0 in any state: go to IDLE next cycle; rand_stall drops the same edge.
- Result: a FREE interval of len cycles is followed by exactly len' stall cycles, registered, with no bubbles between intervals.
- Sticky software stall: sw_stall_next = (stall_on | sw_stall) & ~free_on. free_on wins when both are set in the same cycle.
- Raw stall: raw = rand_stall | sw_stall.
- Gating (combinational on the registered inputs): stall = raw & ~(~stall_q & atom_grant), where stall_q is stall registered.
  - A new stall is deferred while atom_grant is high.
  - An ongoing stall is never dropped by atom_grant.
  - Deferral can last multiple cycles if atom_grant stays high.
- seed_ld: reloads the LFSRs next edge. FSM state and counters are unaffected; the current interval completes normally.
- Changing min_len or len_mask affects only subsequent draws.

Optional Feature:
- Macro: CCX_STALL_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and output stall_cyc (NUM_CH*CNT_W*2).
  - Per channel, a saturating counter of cycles with stall = 1 and a saturating counter of deferrals (cycles where raw & ~stall).
  - stats_clr zeroes both next edge. Clear wins over increment.
- Undefined: no counters, no extra ports, stall path identical.

Decomposition:
- Package ccx_stall_pkg:
  - FSM state enum {IDLE, FREE, STALL}
  - LFSR tap constants keyed by LFSR_W
  - function next_lfsr()
  - function draw_len() (min/mask/saturate/zero-to-one rule)
- Sub-module ccx_stall_chan: one channel (LFSR, FSM, counter, sticky software stall, gate).
- Top ccx_stall_gen: generate loop over NUM_CH, plus optional stats.

Test Plan:
- Reset, rand_en = 0, stall_on = 8'h05 for one cycle → stall = 8'h05 from the next cycle and held. Then free_on = 8'h01 → stall = 8'h04 next cycle.
- stall_on[3] = free_on[3] = 1 in the same cycle with sw_stall[3] = 0 → sw_stall[3] stays 0.
- rand_en = 1, min_len = 4, len_mask = 0 → every channel alternates exactly 4 free / 4 stall cycles after a 1-cycle IDLE; periodic check over 200 cycles.
- min_len = 0, len_mask = 0 → 1 free / 1 stall toggling; no zero-length intervals.
- sw_stall rising in the same cycle as atom_grant[2] = 1 → stall[2] stays 0 that cycle and asserts the next. With stall[2] already 1 and atom_grant[2] = 1 → stall[2] stays 1.
- Seed reproducibility and mid-interval control:
  - seed_ld with seed = 16'h1234 on two runs → identical rand_stall traces over 1000 cycles.
  - rand_en dropped mid-STALL → rand_stall = 0 next cycle.
  - rst asserted mid-STALL → all outputs 0 immediately, without waiting for a clock edge.
